// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU types for the pipeline sequencer and hazard logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pipe_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module : pipeline_ctrl_if
// Brief  : Status inputs and latch/PC control outputs of the pipeline sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             mem_halt;
    logic             ex_memread;
    regbits_t         ex_rd;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             ex_branch_taken;
    logic             id_jump;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    // Sequencer side
    modport master (
        input  ihit, dhit, mem_dren, mem_dwen, mem_halt, ex_memread,
               ex_rd, id_rs, id_rt, ex_branch_taken, id_jump,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt
    );

    // Datapath side
    modport slave (
        output ihit, dhit, mem_dren, mem_dwen, mem_halt, ex_memread,
               ex_rd, id_rs, id_rt, ex_branch_taken, id_jump,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt
    );

endinterface

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module : hazard_detect
// Brief  : Load-use hazard: load in EX writing a register read by ID.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     i_ex_memread,
    input  regbits_t i_ex_rd,
    input  regbits_t i_id_rs,
    input  regbits_t i_id_rt,
    output logic     o_lu
);

    // $zero is never a real dependency
    assign o_lu = i_ex_memread && (i_ex_rd != '0) &&
                  ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Per-cycle enable/flush sequencer for the pipeline latches and PC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    pipeline_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_t      r_state;
    pipe_state_t      w_state_nxt;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_dstall;
    logic w_lu;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

    assign w_dstall = (bus.mem_dren || bus.mem_dwen) && !bus.dhit;

    hazard_detect u_hazard_detect (
        .i_ex_memread (bus.ex_memread),
        .i_ex_rd      (bus.ex_rd),
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .o_lu         (w_lu)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;

        if (nRST && (r_state == RUN)) begin
            if (w_dstall) begin
                w_memwb_flush = 1'b1;
            end else if (!bus.ihit) begin
                // Retire MEM and bubble behind it so its access is not reissued
                w_exmem_flush = 1'b1;
                w_memwb_en    = 1'b1;
            end else begin
                w_pc_en    = 1'b1;
                w_ifid_en  = 1'b1;
                w_idex_en  = 1'b1;
                w_exmem_en = 1'b1;
                w_memwb_en = 1'b1;
                if (bus.ex_branch_taken) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_lu) begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                end else if (bus.id_jump) begin
                    w_ifid_flush = 1'b1;
                end
            end

            if (bus.mem_halt && !w_dstall) begin
                w_state_nxt = HALTED;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_halt      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_halt  <= (w_state_nxt == HALTED);
            if ((r_state == RUN) && !w_pc_en && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.halt        = r_halt;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Per cycle, decides enable/flush of every latch and the PC enable from ihit, dhit, load-use hazard, taken branch, jump and halt.
- Holds a two-state run/halt FSM and a saturating stall-cycle counter.
- Sits beside the datapath; drives the en/flush inputs of each pipeline-latch interface and the PC register.

Parameters:
CNT_W, 32, width of stall_cnt (saturating)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  synchronous active-low reset
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
mem_dren  in  1  EX/MEM latch holds a load
mem_dwen  in  1  EX/MEM latch holds a store
mem_halt  in  1  EX/MEM latch holds a halt
ex_memread  in  1  ID/EX latch holds a load
ex_rd  in  5  destination reg of ID/EX instruction
id_rs  in  5  rs of IF/ID instruction
id_rt  in  5  rt of IF/ID instruction
ex_branch_taken  in  1  branch resolved taken in EX
id_jump  in  1  j/jal/jr decoded in ID
pc_en  out  1  PC register load enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads bubble (all zero); flush dominates en
halt  out  1  registered; processor halted
stall_cnt  out  CNT_W  cycles in RUN with pc_en=0

Behaviour:
- Clocking/reset: one clock CLK; reset nRST synchronous, active-low.
- Reset values: state=RUN, halt=0, stall_cnt=0.
- While nRST=0, all en=0 and all flush=0 combinationally.
- Latch controls are combinational from inputs and state (zero latency); halt and stall_cnt are registered.
- Derived terms:
  - mem_req = mem_dren|mem_dwen
  - dstall = mem_req & ~dhit
  - lu = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs)|(ex_rd==id_rt))
- RUN, priority order (first match wins):
  1. dstall: pc/ifid/idex/exmem en=0; memwb_flush=1.
  2. ~ihit: pc/ifid/idex en=0; exmem_flush=1; memwb_en=1. This retires the MEM instruction and prevents re-issuing its data access.
  3. ihit: all en=1, then apply the overlay below.
- Overlay (case 3 only), priority ex_branch_taken > lu > id_jump:
  - ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1; lu is ignored.
  - lu: pc_en=0, ifid_en=0, idex_flush=1; a jump in ID waits until lu clears.
  - id_jump: pc_en=1, ifid_flush=1.
- Branch or jump arriving while ~ihit or dstall: no flush that cycle. The instruction is held in its latch and the flush is applied in the first ihit cycle.
- Halt transition: mem_halt=1 and not dstall → next state HALTED, halt<=1 next edge. That cycle the halt instruction advances normally.
- HALTED: all en=0, all flush=0, halt=1; exits only via nRST=0.
- stall_cnt:
  - Increments on each RUN cycle with pc_en=0, including lu, ~ihit and dstall cycles.
  - Saturates at 2^CNT_W-1.
  - Frozen in HALTED.
- Reset mid-stall: next cycle is RUN with counter 0; no pending flush is remembered.
- Simultaneous dhit & ihit with mem_req: case 3 applies; all stages advance.

Decomposition:
- cpu_types_pkg gets pipe_state_t enum {RUN, HALTED}; regbits_t is reused for the 5-bit register fields.
- Sub-module hazard_detect (combinational): ex_memread, ex_rd, id_rs, id_rt → lu. It is separately unit-testable and reused when forwarding is added.

Test Plan:
- ihit=1, no hazards, 10 cycles → every en=1, every flush=0, stall_cnt stays 0.
- Load in EX with ex_rd=5, id_rt=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0→1. Repeat with ex_rd=0 → no stall.
- mem_dren=1, dhit=0 for 3 cycles, then dhit=1, ihit=0 → 3 cycles of frozen front with memwb_flush=1. Then exmem_flush=1, memwb_en=1. stall_cnt=4.
- ex_branch_taken=1 with lu=1 and id_jump=1, ihit=1 → pc_en=1, ifid_flush=1, idex_flush=1. Same with ihit=0 → no flush; the flush occurs in the next ihit cycle.
- mem_halt=1 with dhit irrelevant, mem_req=0 → halt=1 after the edge; all en=0 thereafter for 20 cycles. nRST=0 for one edge → halt=0, stall_cnt=0.
- CNT_W=4, force ihit=0 for 20 cycles → stall_cnt saturates at 15.
